// File: rtl/uart_nios2_cpu_ocimem_arbiter.sv
// Arbiter for the Nios II OCI debug RAM: shares one synchronous single-port RAM
// between the CPU Avalon slave and the JTAG debug strobes, with round-robin on ties.
module uart_nios2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_rd_done,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RD_WAIT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                owner_jtag_q, owner_jtag_d;
  logic                last_jtag_q, last_jtag_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                slot_valid_q, slot_valid_d;
  logic                slot_wr_q, slot_wr_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]   slot_data_q, slot_data_d;
  logic [DATA_W-1:0]   cpu_readdata_q, cpu_readdata_d;
  logic                cpu_rdv_q, cpu_rdv_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                rd_done_q, rd_done_d;
  logic                overrun_q, overrun_d;

  logic jgrant_s, cgrant_s, cpend_s, op_strobe_s, op_s, conflict_s;
  logic unused_jdo_s;

  assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};
  assign cpend_s      = cpu_read | cpu_write;
  assign op_strobe_s  = take_action_ocimem_b | take_no_action_ocimem_a;
  assign conflict_s   = take_action_ocimem_a & op_strobe_s;
  assign op_s         = op_strobe_s & ~take_action_ocimem_a;

  // Grant selection; nothing is granted while in reset or waiting on read data
  always_comb begin
    jgrant_s = 1'b0;
    cgrant_s = 1'b0;
    if (reset_n && (state_q == ST_IDLE)) begin
      if (slot_valid_q && cpend_s) begin
        jgrant_s = ~last_jtag_q;
        cgrant_s = last_jtag_q;
      end else begin
        jgrant_s = slot_valid_q;
        cgrant_s = cpend_s;
      end
    end else begin
      jgrant_s = 1'b0;
      cgrant_s = 1'b0;
    end
  end

  // RAM port mux driven in the grant cycle
  always_comb begin
    ram_addr   = '0;
    ram_wren   = 1'b0;
    ram_byteen = 4'h0;
    ram_wdata  = '0;
    if (jgrant_s) begin
      ram_addr   = slot_addr_q;
      ram_wren   = slot_wr_q;
      ram_byteen = 4'hF;
      ram_wdata  = slot_data_q;
    end else if (cgrant_s) begin
      ram_addr   = cpu_address;
      ram_wren   = cpu_write;
      ram_byteen = cpu_byteenable;
      ram_wdata  = cpu_writedata;
    end else begin
      ram_addr   = '0;
    end
  end

  // Next-state for JTAG capture, arbitration history and read returns
  always_comb begin
    state_d        = state_q;
    owner_jtag_d   = owner_jtag_q;
    last_jtag_d    = last_jtag_q;
    jaddr_d        = jaddr_q;
    slot_valid_d   = slot_valid_q;
    slot_wr_d      = slot_wr_q;
    slot_addr_d    = slot_addr_q;
    slot_data_d    = slot_data_q;
    cpu_readdata_d = cpu_readdata_q;
    cpu_rdv_d      = 1'b0;
    mon_dreg_d     = mon_dreg_q;
    rd_done_d      = 1'b0;
    overrun_d      = overrun_q | conflict_s | (op_s & slot_valid_q & ~jgrant_s);

    // An op strobe snapshots jaddr so a later load cannot retarget it
    if (take_action_ocimem_a) begin
      jaddr_d = jdo[ADDR_W+9:10];
    end else if (op_s) begin
      jaddr_d = jaddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      jaddr_d = jaddr_q;
    end

    if (op_s) begin
      slot_valid_d = 1'b1;
      slot_wr_d    = take_action_ocimem_b;
      slot_addr_d  = jaddr_q;
      slot_data_d  = jdo[34:3];
    end else if (jgrant_s) begin
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (jgrant_s || cgrant_s) begin
          last_jtag_d  = jgrant_s;
          owner_jtag_d = jgrant_s;
          if (jgrant_s ? !slot_wr_q : !cpu_write) begin
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (owner_jtag_q) begin
          mon_dreg_d = ram_rdata;
          rd_done_d  = 1'b1;
        end else begin
          cpu_readdata_d = ram_rdata;
          cpu_rdv_d      = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      owner_jtag_q   <= 1'b0;
      last_jtag_q    <= 1'b0;
      jaddr_q        <= '0;
      slot_valid_q   <= 1'b0;
      slot_wr_q      <= 1'b0;
      slot_addr_q    <= '0;
      slot_data_q    <= '0;
      cpu_readdata_q <= '0;
      cpu_rdv_q      <= 1'b0;
      mon_dreg_q     <= '0;
      rd_done_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_jtag_q   <= owner_jtag_d;
      last_jtag_q    <= last_jtag_d;
      jaddr_q        <= jaddr_d;
      slot_valid_q   <= slot_valid_d;
      slot_wr_q      <= slot_wr_d;
      slot_addr_q    <= slot_addr_d;
      slot_data_q    <= slot_data_d;
      cpu_readdata_q <= cpu_readdata_d;
      cpu_rdv_q      <= cpu_rdv_d;
      mon_dreg_q     <= mon_dreg_d;
      rd_done_q      <= rd_done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign cpu_waitrequest   = ~cgrant_s;
  assign cpu_readdata      = cpu_readdata_q;
  assign cpu_readdatavalid = cpu_rdv_q;
  assign MonDReg           = mon_dreg_q;
  assign jtag_rd_done      = rd_done_q;
  assign jtag_overrun      = overrun_q;
  assign jtag_busy         = slot_valid_q | ((state_q == ST_RD_WAIT) & owner_jtag_q);

endmodule

// File: tb/tb_uart_nios2_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural byte-enabled RAM.
module tb_uart_nios2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        jtag_rd_done, jtag_busy, jtag_overrun;

  logic [31:0] mem [256] = '{default: 32'h0};
  int n_checks = 0;
  int n_errors = 0;

  uart_nios2_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_na),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .jtag_rd_done(jtag_rd_done), .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_wren && ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [37:0] jaddr_word(input logic [7:0] a);
    return {20'd0, a, 10'd0};
  endfunction

  function automatic logic [37:0] jdata_word(input logic [31:0] d);
    return {3'd0, d, 3'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; jdo = 38'd0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    cpu_address = 8'h10; cpu_read = 1'b1; cpu_write = 1'b0;
    cpu_writedata = 32'h0; cpu_byteenable = 4'h0;

    // Reset state, with a CPU read held to prove waitrequest is forced
    cyc(); cyc(); #1;
    chk("rst_wait", {31'd0, cpu_waitrequest}, 32'd1);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_rdv", {31'd0, cpu_readdatavalid}, 32'd0);
    chk("rst_rdata", cpu_readdata, 32'd0);
    chk("rst_mon", MonDReg, 32'd0);
    chk("rst_flags", {29'd0, jtag_rd_done, jtag_busy, jtag_overrun}, 32'd0);
    cpu_read = 1'b0;
    cyc(); reset_n = 1'b1;

    // Tie right after reset: JTAG write wins, CPU read then sees its data
    cyc(); take_a = 1'b1; jdo = jaddr_word(8'h10);
    cyc(); take_a = 1'b0; take_b = 1'b1; jdo = jdata_word(32'hDEAD0001); #1;
    chk("tie_busy0", {31'd0, jtag_busy}, 32'd0);
    cyc(); take_b = 1'b0; cpu_read = 1'b1; cpu_address = 8'h10; #1;
    chk("tie_busy1", {31'd0, jtag_busy}, 32'd1);
    chk("tie_jwr", {19'd0, ram_wren, ram_byteen, ram_addr}, {19'd0, 1'b1, 4'hF, 8'h10});
    chk("tie_jwdata", ram_wdata, 32'hDEAD0001);
    chk("tie_cwait", {31'd0, cpu_waitrequest}, 32'd1);
    cyc(); #1;
    chk("tie_cgrant", {22'd0, cpu_waitrequest, ram_wren, ram_addr}, {22'd0, 1'b0, 1'b0, 8'h10});
    cyc(); cpu_read = 1'b0; #1;
    chk("tie_rdwait", {30'd0, cpu_waitrequest, cpu_readdatavalid}, {30'd0, 1'b1, 1'b0});
    cyc(); #1;
    chk("tie_rdv", {31'd0, cpu_readdatavalid}, 32'd1);
    chk("tie_rdata", cpu_readdata, 32'hDEAD0001);

    // Auto-increment with wrap FE, FF, 00
    cyc(); take_a = 1'b1; jdo = jaddr_word(8'hFE);
    cyc(); take_a = 1'b0; take_b = 1'b1; jdo = jdata_word(32'd1); #1;
    chk("inc_idle", {31'd0, ram_wren}, 32'd0);
    cyc(); jdo = jdata_word(32'd2); #1;
    chk("inc_wr0", {23'd0, ram_wren, ram_addr}, {23'd0, 1'b1, 8'hFE});
    chk("inc_d0", ram_wdata, 32'd1);
    cyc(); jdo = jdata_word(32'd3); #1;
    chk("inc_wr1", {23'd0, ram_wren, ram_addr}, {23'd0, 1'b1, 8'hFF});
    chk("inc_d1", ram_wdata, 32'd2);
    cyc(); take_b = 1'b0; #1;
    chk("inc_wr2", {23'd0, ram_wren, ram_addr}, {23'd0, 1'b1, 8'h00});
    chk("inc_d2", ram_wdata, 32'd3);
    chk("inc_ovr", {31'd0, jtag_overrun}, 32'd0);
    cyc(); take_na = 1'b1; #1;
    chk("inc_quiet", {30'd0, ram_wren, jtag_busy}, 32'd0);
    cyc(); take_na = 1'b0; #1;
    chk("inc_jaddr01", {23'd0, ram_wren, ram_addr}, {23'd0, 1'b0, 8'h01});
    cyc(); #1;
    chk("inc_rdbusy", {30'd0, jtag_busy, jtag_rd_done}, {30'd0, 1'b1, 1'b0});
    cyc(); take_a = 1'b1; jdo = jaddr_word(8'hFE); #1;
    chk("inc_done01", {30'd0, jtag_rd_done, jtag_busy}, {30'd0, 1'b1, 1'b0});
    chk("inc_mon01", MonDReg, 32'd0);
    cyc(); take_a = 1'b0; take_na = 1'b1; #1;
    chk("inc_donefall", {31'd0, jtag_rd_done}, 32'd0);
    cyc(); take_na = 1'b0; #1;
    chk("inc_rdaddr", {24'd0, ram_addr}, 32'h0000_00FE);
    cyc(); cyc(); #1;
    chk("inc_donefe", {31'd0, jtag_rd_done}, 32'd1);
    chk("inc_monfe", MonDReg, 32'd1);

    // Byte enables, back-to-back CPU writes
    cyc(); cpu_write = 1'b1; cpu_address = 8'h30; cpu_writedata = 32'h11223344; cpu_byteenable = 4'hF; #1;
    chk("be_wr0", {18'd0, cpu_waitrequest, ram_wren, ram_byteen, ram_addr}, {18'd0, 1'b0, 1'b1, 4'hF, 8'h30});
    cyc(); cpu_writedata = 32'hAABBCCDD; cpu_byteenable = 4'b0101; #1;
    chk("be_wr1", {18'd0, cpu_waitrequest, ram_wren, ram_byteen, ram_addr}, {18'd0, 1'b0, 1'b1, 4'b0101, 8'h30});
    chk("be_wdata", ram_wdata, 32'hAABBCCDD);
    cyc(); cpu_write = 1'b0; cpu_read = 1'b1; #1;
    chk("be_rgrant", {31'd0, cpu_waitrequest}, 32'd0);
    cyc(); cpu_read = 1'b0;
    cyc(); #1;
    chk("be_rdv", {31'd0, cpu_readdatavalid}, 32'd1);
    chk("be_rdata", cpu_readdata, 32'h11BB33DD);

    // Address snapshot: queued read keeps address 5 across a load to 40
    cyc(); take_a = 1'b1; jdo = jaddr_word(8'h05);
    cyc(); take_a = 1'b0; take_na = 1'b1; cpu_read = 1'b1; cpu_address = 8'h30; #1;
    chk("snap_cgrant", {23'd0, cpu_waitrequest, ram_addr}, {23'd0, 1'b0, 8'h30});
    cyc(); take_na = 1'b0; cpu_read = 1'b0; take_a = 1'b1; jdo = jaddr_word(8'h40);
    cyc(); take_a = 1'b0; #1;
    chk("snap_addr5", {23'd0, ram_wren, ram_addr}, {23'd0, 1'b0, 8'h05});
    chk("snap_rdv", {31'd0, cpu_readdatavalid}, 32'd1);
    cyc(); cyc(); take_na = 1'b1; #1;
    chk("snap_done", {31'd0, jtag_rd_done}, 32'd1);
    cyc(); take_na = 1'b0; #1;
    chk("snap_addr40", {24'd0, ram_addr}, 32'h0000_0040);
    cyc(); cyc(); #1;
    chk("snap_done40", {31'd0, jtag_rd_done}, 32'd1);

    // Fairness: CPU reads and JTAG read strobes every cycle
    cyc(); take_a = 1'b1; jdo = jaddr_word(8'hFF);
    cyc(); take_a = 1'b0; take_na = 1'b1; cpu_read = 1'b1; cpu_address = 8'h30; #1;
    chk("fair_f0", {31'd0, cpu_waitrequest}, 32'd0);
    cyc(); #1;
    chk("fair_f1", {30'd0, cpu_waitrequest, jtag_overrun}, {30'd0, 1'b1, 1'b0});
    cyc(); #1;
    chk("fair_f2", {21'd0, cpu_waitrequest, jtag_overrun, cpu_readdatavalid, ram_addr}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h00});
    chk("fair_rdata", cpu_readdata, 32'h11BB33DD);
    cyc(); #1;
    chk("fair_f3", {31'd0, cpu_waitrequest}, 32'd1);
    cyc(); #1;
    chk("fair_f4", {30'd0, cpu_waitrequest, jtag_rd_done}, {30'd0, 1'b0, 1'b1});
    chk("fair_mon", MonDReg, 32'd3);
    cyc(); take_na = 1'b0; cpu_read = 1'b0;
    cyc(); cyc(); cyc(); cyc();

    // Reset in the middle of a CPU read with a JTAG op queued
    cyc(); take_na = 1'b1; cpu_read = 1'b1; cpu_address = 8'h30;
    cyc(); take_na = 1'b0; cpu_read = 1'b0; #1;
    chk("mid_busy", {31'd0, jtag_busy}, 32'd1);
    #1 reset_n = 1'b0; cpu_read = 1'b1; #1;
    chk("mid_rst", {28'd0, cpu_waitrequest, cpu_readdatavalid, jtag_busy, jtag_overrun}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("mid_mon", MonDReg, 32'd0);
    chk("mid_ram", {23'd0, ram_wren, ram_addr}, 32'd0);
    cyc(); #1;
    chk("mid_rdv_in_rst", {31'd0, cpu_readdatavalid}, 32'd0);
    cpu_read = 1'b0; reset_n = 1'b1;
    cyc(); #1;
    chk("mid_after", {30'd0, cpu_readdatavalid, jtag_busy}, 32'd0);
    cyc(); #1;
    chk("mid_after2", {29'd0, cpu_readdatavalid, jtag_rd_done, jtag_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
